stream_sync_fifo_read: RTL and testbench

// - Read-side controller of the single-clock stream FIFO (successor of the async read controller).
// - Any depth 2..2^ADDRWIDTH, not only power of two. Wrap-bit binary pointers.
// - Optional FWFT prefetch. Precise occupancy, sticky error, optional almost-empty flag.
// - Sits between the write controller (same r_clk) and a 1-cycle-latency dual-port RAM.

---
 rtl/stream_sync_fifo_read.sv | 143 ++++++++++++++
 tb/tb_stream_sync_fifo_read.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_sync_fifo_read.sv
// -----------------------------------------------------------------------------
// stream_sync_fifo_read
//
// Read-side controller of a single-clock stream FIFO. It owns the read
// pointer, drives the read port of a dual-port RAM with one cycle of read
// latency, and reports exact occupancy together with a sticky error flag.
//
// Depth may be any value from 2 to 2^ADDRWIDTH. Pointers are binary with an
// extra MSB that toggles every time the address wraps from FIFODEPTH-1 to 0,
// which keeps full and empty distinguishable for non-power-of-two depths.
//
// FWFTEN=1 prefetches the head entry so that it falls through to the RAM
// output without a pop. FWFTEN=0 fetches data only in response to r_en.
//
// Optional feature: define STREAM_SYNC_FIFO_READ_AEMPTY_EN to add the r_aethr
// input and the registered r_aempty output. When the macro is undefined both
// ports and all almost-empty logic are absent.
// -----------------------------------------------------------------------------
module stream_sync_fifo_read #(
    parameter int FWFTEN    = 1,
    parameter int ADDRWIDTH = 6,
    parameter int FIFODEPTH = 44
) (
    input  logic                 r_clk,
    input  logic                 r_rst,
    input  logic                 r_en,
    input  logic [ADDRWIDTH:0]   w_ptr,
`ifdef STREAM_SYNC_FIFO_READ_AEMPTY_EN
    input  logic [ADDRWIDTH:0]   r_aethr,
    output logic                 r_aempty,
`endif
    output logic                 mem_ren,
    output logic [ADDRWIDTH-1:0] rbin,
    output logic [ADDRWIDTH:0]   rptr,
    output logic                 r_valid,
    output logic [ADDRWIDTH:0]   r_counter,
    output logic                 r_error
);

    // Depth and last valid address, sized to the pointer and address fields.
    localparam logic [ADDRWIDTH:0]   DEPTH     = FIFODEPTH[ADDRWIDTH:0];
    localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(FIFODEPTH - 1);
    localparam logic                 FWFT_ON   = (FWFTEN != 0);

    // Pointer layout: MSB is the wrap toggle, the rest is the RAM address.
    typedef struct packed {
        logic                 wrap;
        logic [ADDRWIDTH-1:0] addr;
    } ptr_t;

    // Advance a pointer by one entry, wrapping at FIFODEPTH-1 rather than at
    // the natural binary boundary so that odd depths wrap without a gap.
    function automatic ptr_t ptr_advance(input ptr_t p);
        ptr_t w_n;
        if (p.addr == LAST_ADDR) begin
            w_n.wrap = ~p.wrap;
            w_n.addr = '0;
        end else begin
            w_n.wrap = p.wrap;
            w_n.addr = p.addr + 1'b1;
        end
        return w_n;
    endfunction

    // Entries between read and write pointer. On the same lap this is the
    // plain address difference; a write pointer one lap ahead adds the depth.
    // A write address behind the read address on the same lap underflows to a
    // large value, which the overflow check below reports as an error.
    function automatic logic [ADDRWIDTH:0] occupancy(input ptr_t wp, input ptr_t rp);
        logic [ADDRWIDTH:0] w_wa;
        logic [ADDRWIDTH:0] w_ra;
        w_wa = {1'b0, wp.addr};
        w_ra = {1'b0, rp.addr};
        if (wp.wrap == rp.wrap) begin
            return w_wa - w_ra;
        end else begin
            return DEPTH - w_ra + w_wa;
        end
    endfunction

    ptr_t               r_rptr;
    ptr_t               w_wptr;
    ptr_t               w_rptr_next;
    logic               w_zero;
    logic               w_fwft;
    logic               w_inc;
    logic [ADDRWIDTH:0] w_occ;
    logic               w_occ_over;
    logic               w_waddr_bad;

    assign w_wptr = ptr_t'(w_ptr);

    // Pop/prefetch decision and the pointer/occupancy it leads to.
    // NOTE: every signal in this block gets a value on every path, so no latch is inferred.
    always_comb begin
        w_zero      = (r_counter == '0);
        w_fwft      = FWFT_ON & ~r_valid & ~w_zero;
        w_inc       = (r_en & ~w_zero) | w_fwft;
        w_rptr_next = r_rptr;
        if (w_inc) begin
            w_rptr_next = ptr_advance(r_rptr);
        end
        w_occ       = occupancy(w_wptr, w_rptr_next);
        w_occ_over  = (w_occ > DEPTH);
        w_waddr_bad = ({1'b0, w_wptr.addr} >= DEPTH);
    end

    assign mem_ren = w_inc;
    assign rptr    = r_rptr;
    assign rbin    = r_rptr.addr;

    // Read pointer, occupancy, valid and sticky error registers.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            r_rptr    <= '0;
            r_counter <= '0;
            r_valid   <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_rptr    <= w_rptr_next;
            r_counter <= w_occ;
            // Valid follows the RAM read: a fetch makes it 1, a pop on an
            // empty FIFO clears it, otherwise it holds.
            if (r_en | w_fwft) begin
                r_valid <= ~w_zero;
            end
            r_error   <= r_error | w_occ_over | w_waddr_bad;
        end
    end

`ifdef STREAM_SYNC_FIFO_READ_AEMPTY_EN
    // Almost-empty flag, registered in step with r_counter.
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            r_aempty <= 1'b1;
        end else begin
            r_aempty <= (w_occ <= r_aethr);
        end
    end
`endif

endmodule

// File: tb/tb_stream_sync_fifo_read.sv
// -----------------------------------------------------------------------------
// tb_stream_sync_fifo_read
//
// Two instances share clock and reset: dut_f prefetches (FWFTEN=1) and dut_n
// fetches only on r_en (FWFTEN=0); both use ADDRWIDTH=6, FIFODEPTH=44.
// Almost-empty checks are compiled in when STREAM_SYNC_FIFO_READ_AEMPTY_EN is
// defined.
// -----------------------------------------------------------------------------
module tb_stream_sync_fifo_read;

    localparam int AW    = 6;
    localparam int DEPTH = 44;

    logic          clk = 1'b0;
    logic          rst;
    logic          en_f, en_n;
    logic [AW:0]   w_f, w_n;
    logic          ren_f, ren_n;
    logic [AW-1:0] rbin_f, rbin_n;
    logic [AW:0]   rptr_f, rptr_n;
    logic          valid_f, valid_n;
    logic [AW:0]   cnt_f, cnt_n;
    logic          err_f, err_n;
`ifdef STREAM_SYNC_FIFO_READ_AEMPTY_EN
    logic [AW:0]   aethr;
    logic          aempty_f, aempty_n;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stream_sync_fifo_read #(.FWFTEN(1), .ADDRWIDTH(AW), .FIFODEPTH(DEPTH)) dut_f (
        .r_clk(clk), .r_rst(rst), .r_en(en_f), .w_ptr(w_f),
`ifdef STREAM_SYNC_FIFO_READ_AEMPTY_EN
        .r_aethr(aethr), .r_aempty(aempty_f),
`endif
        .mem_ren(ren_f), .rbin(rbin_f), .rptr(rptr_f), .r_valid(valid_f),
        .r_counter(cnt_f), .r_error(err_f)
    );

    stream_sync_fifo_read #(.FWFTEN(0), .ADDRWIDTH(AW), .FIFODEPTH(DEPTH)) dut_n (
        .r_clk(clk), .r_rst(rst), .r_en(en_n), .w_ptr(w_n),
`ifdef STREAM_SYNC_FIFO_READ_AEMPTY_EN
        .r_aethr(aethr), .r_aempty(aempty_n),
`endif
        .mem_ren(ren_n), .rbin(rbin_n), .rptr(rptr_n), .r_valid(valid_n),
        .r_counter(cnt_n), .r_error(err_n)
    );

    typedef struct {
        logic        en;
        logic [AW:0] w;
        logic        ren;    // mem_ren before the edge
        logic [AW:0] rptr;   // after the edge
        logic        valid;
        logic [AW:0] cnt;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference pointer advance: address wraps 43 -> 0 and the MSB toggles.
    function automatic logic [AW:0] adv(input logic [AW:0] p);
        logic [AW-1:0] a;
        a = p[AW-1:0];
        if (a == AW'(DEPTH - 1)) return {~p[AW], {AW{1'b0}}};
        return {p[AW], a + 1'b1};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en_f = 1'b0; en_n = 1'b0; w_f = '0; w_n = '0;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset_f(input string tag);
        check({tag, "_f_rptr"},  rptr_f,  0);
        check({tag, "_f_rbin"},  rbin_f,  0);
        check({tag, "_f_cnt"},   cnt_f,   0);
        check({tag, "_f_valid"}, valid_f, 0);
        check({tag, "_f_err"},   err_f,   0);
        check({tag, "_f_ren"},   ren_f,   0);
    endtask

    task automatic check_reset_n(input string tag);
        check({tag, "_n_rptr"},  rptr_n,  0);
        check({tag, "_n_cnt"},   cnt_n,   0);
        check({tag, "_n_valid"}, valid_n, 0);
        check({tag, "_n_err"},   err_n,   0);
        check({tag, "_n_ren"},   ren_n,   0);
    endtask

    // Drive dut_n for one cycle, then sample after the edge.
    task automatic step_n(input logic en, input logic [AW:0] w);
        @(negedge clk);
        en_n = en; w_n = w;
        @(posedge clk); #1;
    endtask

    logic [AW:0] sb [$];
    logic [AW:0] wp;
    logic [AW:0] exp_p;

    initial begin
        rst = 1'b1; en_f = 1'b0; en_n = 1'b0; w_f = '0; w_n = '0;
`ifdef STREAM_SYNC_FIFO_READ_AEMPTY_EN
        aethr = 7'd4;
`endif

        // FWFTEN=0 vectors: three words in, three pops, then pops on empty.
        tbl[0]  = '{1'b0, 7'd3, 1'b0, 7'd0, 1'b0, 7'd3};
        tbl[1]  = '{1'b0, 7'd3, 1'b0, 7'd0, 1'b0, 7'd3};
        tbl[2]  = '{1'b1, 7'd3, 1'b1, 7'd1, 1'b1, 7'd2};
        tbl[3]  = '{1'b1, 7'd3, 1'b1, 7'd2, 1'b1, 7'd1};
        tbl[4]  = '{1'b1, 7'd3, 1'b1, 7'd3, 1'b1, 7'd0};
        tbl[5]  = '{1'b1, 7'd3, 1'b0, 7'd3, 1'b0, 7'd0};
        tbl[6]  = '{1'b0, 7'd3, 1'b0, 7'd3, 1'b0, 7'd0};
        tbl[7]  = '{1'b1, 7'd3, 1'b0, 7'd3, 1'b0, 7'd0};
        tbl[8]  = '{1'b1, 7'd5, 1'b0, 7'd3, 1'b0, 7'd2};
        tbl[9]  = '{1'b1, 7'd6, 1'b1, 7'd4, 1'b1, 7'd2};
        tbl[10] = '{1'b0, 7'd6, 1'b0, 7'd4, 1'b1, 7'd2};

        // Reset values on both instances.
        do_reset();
        #1;
        check_reset_f("rst0");
        check_reset_n("rst0");
`ifdef STREAM_SYNC_FIFO_READ_AEMPTY_EN
        check("rst0_aempty", aempty_n, 1);
`endif

        // Table-driven FWFTEN=0 sequence.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            en_n = tbl[i].en; w_n = tbl[i].w;
            #1;
            check($sformatf("tbl%0d_ren", i), ren_n, tbl[i].ren);
            @(posedge clk); #1;
            check($sformatf("tbl%0d_rptr", i),  rptr_n,  tbl[i].rptr);
            check($sformatf("tbl%0d_rbin", i),  rbin_n,  tbl[i].rptr[AW-1:0]);
            check($sformatf("tbl%0d_valid", i), valid_n, tbl[i].valid);
            check($sformatf("tbl%0d_cnt", i),   cnt_n,   tbl[i].cnt);
            check($sformatf("tbl%0d_err", i),   err_n,   0);
        end

        // FWFTEN=1 first-word latency.
        do_reset();
        w_f = 7'd1;
        #1;
        check("fwft_ren_c0", ren_f, 0);
        @(posedge clk); #1;
        check("fwft_cnt_c1", cnt_f, 1);
        check("fwft_valid_c1", valid_f, 0);
        @(negedge clk); #1;
        check("fwft_ren_c1", ren_f, 1);
        @(posedge clk); #1;
        check("fwft_valid_c2", valid_f, 1);
        check("fwft_cnt_c2", cnt_f, 0);
        check("fwft_rptr_c2", rptr_f, 1);
        @(negedge clk); #1;
        check("fwft_ren_c2", ren_f, 0);

        // Continuous push/pop of 100 words through the wrap; scoreboard holds
        // the pointer of every written entry in write order.
        wp = 7'd1;
        for (int c = 0; c < 104; c++) begin
            @(negedge clk);
            if (c < 100) begin
                sb.push_back(wp);
                wp = adv(wp);
            end
            w_f = wp; en_f = 1'b1;
            #1;
            if (ren_f) begin
                if (sb.size() == 0) begin
                    check("stream_sb_underrun", 1, 0);
                end else begin
                    exp_p = sb.pop_front();
                    check($sformatf("stream_rptr_c%0d", c), rptr_f, exp_p);
                    check($sformatf("stream_rbin_c%0d", c), rbin_f, exp_p[AW-1:0]);
                end
            end
            @(posedge clk); #1;
            if (c < 100) check($sformatf("stream_cnt_c%0d", c), cnt_f, 1);
        end
        check("stream_sb_drained", sb.size(), 0);
        check("stream_err", err_f, 0);

        // Full is legal; one entry beyond sets a sticky error.
        do_reset();
        step_n(1'b0, {1'b1, 6'd0});
        check("full_cnt", cnt_n, 44);
        check("full_err", err_n, 0);
        step_n(1'b0, {1'b1, 6'd1});
        check("over_err", err_n, 1);
        step_n(1'b0, {1'b1, 6'd0});
        check("over_err_sticky", err_n, 1);
        check("over_cnt_back", cnt_n, 44);
        step_n(1'b0, {1'b1, 6'd0});
        check("over_err_sticky2", err_n, 1);

        // Write address outside the used range, then reset mid-stream.
        do_reset();
        #1;
        check("addr50_err_pre", err_n, 0);
        @(negedge clk);
        w_n = {1'b0, 6'd50};
        w_f = 7'd5; en_f = 1'b1;
        @(posedge clk); #1;
        check("addr50_err", err_n, 1);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        check("mid_f_busy", (rptr_f != 0) ? 1 : 0, 1);
        @(negedge clk);
        rst = 1'b1; en_f = 1'b0; en_n = 1'b0; w_f = '0; w_n = '0;
        @(posedge clk); #1;
        check_reset_f("midrst");
        check_reset_n("midrst");
        @(negedge clk);
        rst = 1'b0;

`ifdef STREAM_SYNC_FIFO_READ_AEMPTY_EN
        // Almost-empty with threshold 4.
        do_reset();
        step_n(1'b0, 7'd5);
        check("ae_cnt5", cnt_n, 5);
        check("ae_at5", aempty_n, 0);
        step_n(1'b1, 7'd5);
        check("ae_cnt4", cnt_n, 4);
        check("ae_at4", aempty_n, 1);
        step_n(1'b0, 7'd6);
        check("ae_cnt5b", cnt_n, 5);
        check("ae_at5b", aempty_n, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
